// File: rtl/hamming_weight_pkg.sv
// Shared definitions for the Hamming-weight datapath arbitration stage.
//   N_LANES     : default requester count
//   IDX_W       : width of a binary lane index
//   arb_state_t : arbiter FSM states
//   rr_pick     : rotating-priority pick, returns a one-hot winner (zero if no request)
package hamming_weight_pkg;

  localparam int unsigned N_LANES   = 8;
  localparam int unsigned IDX_W     = $clog2(N_LANES);
  localparam int unsigned MAX_LANES = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Rotate req down by ptr, take the lowest set bit, rotate the winner back up.
  // Only the low n bits take part; n is a power of two so wrap is a mask.
  function automatic logic [MAX_LANES-1:0] rr_pick(
    input logic [MAX_LANES-1:0] req,
    input logic [4:0]           ptr,
    input int unsigned          n = N_LANES
  );
    logic [MAX_LANES-1:0] rot;
    logic [MAX_LANES-1:0] win_rot;
    logic [MAX_LANES-1:0] win;
    logic [4:0]           pos;
    logic                 found;
    rot     = '0;
    win_rot = '0;
    win     = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(MAX_LANES); i++) begin
      if (i < int'(n)) begin
        pos    = 5'((32'(ptr) + 32'(i)) & (n - 32'd1));
        rot[i] = req[pos];
      end
    end
    for (int i = 0; i < int'(MAX_LANES); i++) begin
      if (!found && rot[i]) begin
        win_rot[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int i = 0; i < int'(MAX_LANES); i++) begin
      if (i < int'(n)) begin
        pos      = 5'((32'(ptr) + 32'(i)) & (n - 32'd1));
        win[pos] = win_rot[i];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/onehot_to_index_encoder.sv
// One-hot to binary index encoder (combinational).
//   onehot : N-bit one-hot (or all-zero) input
//   index  : binary position of the set bit; 0 when the input is all-zero
module onehot_to_index_encoder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] index
);

  localparam int unsigned IW = $clog2(N);

  // OR of the indices of set bits; exact for one-hot, 0 for all-zero.
  always_comb begin
    index = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (onehot[i]) index = index | IW'(i);
    end
  end

endmodule

// File: rtl/round_robin_encoder_arbiter.sv
// Round-robin arbiter sharing one encoded-index path among N requesters.
// A winner is picked from a rotating priority pointer and held until its request drops;
// there is always at least one idle cycle between owners.
// Optional feature macro: GRANT_TIMEOUT_EN (forcibly revokes a grant after MAX_HOLD cycles).
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-high reset
//   enable      : allows new grants; a held grant is never revoked by it
//   req         : level-sensitive request vector
//   grant       : registered one-hot grant, zero when idle
//   grant_idx   : registered binary index of grant, 0 when idle
//   grant_valid : registered, high exactly when grant is non-zero
//   timeout     : one-cycle pulse when a grant is forcibly revoked (0 without the macro)
module round_robin_encoder_arbiter
  import hamming_weight_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned IDX_W    = $clog2(N)
`ifdef GRANT_TIMEOUT_EN
  ,
  parameter int unsigned MAX_HOLD = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  arb_state_t       state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [N-1:0]     grant_nx;
  logic [IDX_W-1:0] grant_idx_nx;
  logic [N-1:0]     pick;
  logic             expire;

  // Candidate winner for the next IDLE->GRANT transition.
  assign pick = N'(rr_pick(32'(req), 5'(ptr), N));

  // Index is encoded from the next grant so both register together.
  onehot_to_index_encoder #(.N(N)) u_enc (
    .onehot (grant_nx),
    .index  (grant_idx_nx)
  );

`ifdef GRANT_TIMEOUT_EN
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
  logic              timeout_nx;

  // Counts grant cycles already shown; zero on the entry edge.
  assign expire      = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign hold_cnt_nx = (state == GRANT) ? HOLD_W'(hold_cnt + 1'b1) : '0;
  assign timeout_nx  = (state == GRANT) && expire && req[grant_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_nx;
      timeout  <= timeout_nx;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state and next-grant logic.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    grant_nx = grant;
    case (state)
      IDLE: begin
        if (enable && (req != '0)) begin
          state_nx = GRANT;
          grant_nx = pick;
        end
      end
      GRANT: begin
        if (!req[grant_idx] || expire) begin
          state_nx = IDLE;
          grant_nx = '0;
          ptr_nx   = IDX_W'(32'(grant_idx) + 32'd1);
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      grant       <= grant_nx;
      grant_idx   <= grant_idx_nx;
      grant_valid <= (grant_nx != '0);
    end
  end

endmodule

// File: tb/tb_round_robin_encoder_arbiter.sv
// Self-checking bench for round_robin_encoder_arbiter (N=8).
module tb_round_robin_encoder_arbiter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int tests;
  int fails;

  typedef struct {
    logic       en;
    logic [7:0] r;
    logic [7:0] exp_grant;
    logic [2:0] exp_idx;
  } vec_t;

  vec_t vecs[$];

  round_robin_encoder_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      logic [2:0] enc;
      enc = '0;
      for (int i = 0; i < 8; i++) if (grant[i]) enc = 3'(i);
      tests++;
      if (!$onehot0(grant) || (grant_valid != (grant != 8'h00)) || (grant_idx != enc)) begin
        fails++;
        $display("FAIL invariant: grant=%h idx=%0d valid=%b", grant, grant_idx, grant_valid);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] eg, input logic [2:0] ei,
                       input logic et);
    tests++;
    if (grant !== eg || grant_idx !== ei || grant_valid !== (eg != 8'h00) || timeout !== et) begin
      fails++;
      $display("FAIL %s: grant=%h idx=%0d valid=%b timeout=%b, expected grant=%h idx=%0d valid=%b timeout=%b",
               name, grant, grant_idx, grant_valid, timeout, eg, ei, (eg != 8'h00), et);
    end
  endtask

  // Drive inputs, clock once, leave time at 1 ns after the edge.
  task automatic step(input logic en, input logic [7:0] r);
    enable = en;
    req    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b1;
    req    = 8'h00;
    @(posedge clk);
    #1;
    check("reset", 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic void add(input logic en, input logic [7:0] r, input logic [7:0] g,
                              input logic [2:0] i);
    vec_t v;
    v.en = en; v.r = r; v.exp_grant = g; v.exp_idx = i;
    vecs.push_back(v);
  endfunction

  initial begin
    tests  = 0;
    fails  = 0;
    reset  = 1'b1;
    enable = 1'b0;
    req    = 8'h00;

    // Idle requests, then 0x24 -> lane 2, bubble, lane 5 (ptr=3), release (ptr=6).
    for (int i = 0; i < 10; i++) add(1'b1, 8'h00, 8'h00, 3'd0);
    add(1'b1, 8'h24, 8'h04, 3'd2);
    add(1'b1, 8'h24, 8'h04, 3'd2);
    add(1'b1, 8'h20, 8'h00, 3'd0);
    add(1'b1, 8'h20, 8'h20, 3'd5);
    add(1'b1, 8'h00, 8'h00, 3'd0);
    // From ptr=6: 0x41 -> lane 6, release -> ptr=7, 0x41 -> lane 0 (wrap).
    add(1'b1, 8'h41, 8'h40, 3'd6);
    add(1'b1, 8'h01, 8'h00, 3'd0);
    add(1'b1, 8'h41, 8'h01, 3'd0);
    add(1'b1, 8'h40, 8'h00, 3'd0);
    // Request that vanishes before the edge is never granted.
    add(1'b1, 8'h00, 8'h00, 3'd0);

    do_reset();
    foreach (vecs[k]) begin
      step(vecs[k].en, vecs[k].r);
      check($sformatf("vec%0d", k), vecs[k].exp_grant, vecs[k].exp_idx, 1'b0);
    end

    // Fairness: all request, owner holds 3 cycles, drops for one, bubble in between.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      logic [7:0] oh;
      oh = 8'h01 << (k % 8);
      for (int c = 0; c < 3; c++) begin
        step(1'b1, 8'hFF);
        check($sformatf("rr%0d_hold%0d", k, c), oh, 3'(k % 8), 1'b0);
      end
      step(1'b1, 8'hFF & ~oh);
      check($sformatf("rr%0d_bubble", k), 8'h00, 3'd0, 1'b0);
    end

    // enable=0 does not revoke; blocks new grants; pick restarts at ptr=4.
    do_reset();
    step(1'b1, 8'h08); check("en_grant3", 8'h08, 3'd3, 1'b0);
    step(1'b0, 8'h08); check("en_hold3", 8'h08, 3'd3, 1'b0);
    step(1'b0, 8'h83); check("en_drop3", 8'h00, 3'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 8'h83); check($sformatf("en_blocked%0d", c), 8'h00, 3'd0, 1'b0);
    end
    step(1'b1, 8'h83); check("en_ptr4", 8'h80, 3'd7, 1'b0);
    step(1'b1, 8'h00); check("en_release7", 8'h00, 3'd0, 1'b0);

    // Asynchronous reset mid-grant, then ptr back at 0.
    for (int pass = 0; pass < 2; pass++) begin
      logic [7:0] after_req, after_g;
      logic [2:0] after_i;
      after_req = (pass == 0) ? 8'hC0 : 8'hC1;
      after_g   = (pass == 0) ? 8'h40 : 8'h01;
      after_i   = (pass == 0) ? 3'd6  : 3'd0;
      step(1'b1, 8'h20); check("ar_pre5", 8'h20, 3'd5, 1'b0);
      step(1'b1, 8'h00); check("ar_pre_rel", 8'h00, 3'd0, 1'b0);
      step(1'b1, 8'h40); check("ar_grant6", 8'h40, 3'd6, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check($sformatf("ar_async%0d", pass), 8'h00, 3'd0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b1, after_req);
      check($sformatf("ar_after%0d", pass), after_g, after_i, 1'b0);
      step(1'b1, 8'h00); check("ar_release", 8'h00, 3'd0, 1'b0);
    end

    // Long hold with 0x03 held.
    do_reset();
`ifdef GRANT_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 8'h03); check($sformatf("to_hold%0d", c), 8'h01, 3'd0, 1'b0);
    end
    step(1'b1, 8'h03); check("to_pulse", 8'h00, 3'd0, 1'b1);
    step(1'b1, 8'h03); check("to_next", 8'h02, 3'd1, 1'b0);
`else
    for (int c = 0; c < 24; c++) begin
      step(1'b1, 8'h03); check($sformatf("hold%0d", c), 8'h01, 3'd0, 1'b0);
    end
    step(1'b1, 8'h02); check("hold_release", 8'h00, 3'd0, 1'b0);
    step(1'b1, 8'h02); check("hold_next", 8'h02, 3'd1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
